// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU functional unit and its operation
//   sequencer: opcode constants, flag bit positions inside the 4-bit flag
//   word {rsvd/illegal, Zero, Carry, Ovf}, and the sequencer FSM encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

   // Opcodes. 4'h6 is deliberately left undefined; the sequencer accepts it
   // and reports it through the ILLEGAL flag instead of trusting the ALU.
   localparam logic [3:0] INCA   = 4'h0;  // A + 1
   localparam logic [3:0] ADD    = 4'h1;  // A + B
   localparam logic [3:0] SUB    = 4'h2;  // A - B (carry = borrow)
   localparam logic [3:0] AND_OP = 4'h3;  // A & B
   localparam logic [3:0] OR_OP  = 4'h4;  // A | B
   localparam logic [3:0] XOR_OP = 4'h5;  // A ^ B
   localparam logic [3:0] UNDEF  = 4'h6;  // undefined opcode
   localparam logic [3:0] PASSB  = 4'h7;  // B
   localparam logic [3:0] NOTA   = 4'h8;  // ~A
   localparam logic [3:0] ONES   = 4'h9;  // all ones

   // Bit positions inside the 4-bit flag word.
   localparam int OVF     = 0;
   localparam int CARRY   = 1;
   localparam int ZERO    = 2;
   localparam int ILLEGAL = 3;

   // Flag word reported for the undefined opcode.
   localparam logic [3:0] ILLEGAL_FLAGS = 4'b1000;

   // Sequencer FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
//   Bundles the request channel, the registered drive to / result from the
//   peer combinational ALU, the response channel, the sticky-zero control and
//   the completed-operation counter of alu_op_sequencer.
//
//   Handshake rule (both channels): a transfer happens on the rising clock
//   edge where VALID and READY are both high; VALID, once raised, holds its
//   payload stable until that edge; READY may depend combinationally on the
//   other side's signals.
//
//   Modports:
//     master : environment side (request producer, ALU, response consumer)
//     slave  : alu_op_sequencer side
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
   parameter int CNT_W = 16
);
   // request channel
   logic             REQ_VALID;
   logic             REQ_READY;
   logic [3:0]       REQ_INST;
   logic [31:0]      REQ_A;
   logic [31:0]      REQ_B;
   logic             REQ_ACC;
   // peer ALU
   logic [31:0]      ALU_A;
   logic [31:0]      ALU_B;
   logic [3:0]       ALU_INST;
   logic [31:0]      ALU_Z;
   logic [3:0]       ALU_FLAGS;
   // response channel
   logic             RSP_VALID;
   logic             RSP_READY;
   logic [31:0]      RSP_Z;
   logic [3:0]       RSP_FLAGS;
   // status
   logic             STICKY_ZERO;
   logic             STICKY_CLR;
   logic [CNT_W-1:0] OP_COUNT;

   modport master (
      output REQ_VALID, REQ_INST, REQ_A, REQ_B, REQ_ACC,
      output ALU_Z, ALU_FLAGS,
      output RSP_READY, STICKY_CLR,
      input  REQ_READY, ALU_A, ALU_B, ALU_INST,
      input  RSP_VALID, RSP_Z, RSP_FLAGS, STICKY_ZERO, OP_COUNT
   );

   modport slave (
      input  REQ_VALID, REQ_INST, REQ_A, REQ_B, REQ_ACC,
      input  ALU_Z, ALU_FLAGS,
      input  RSP_READY, STICKY_CLR,
      output REQ_READY, ALU_A, ALU_B, ALU_INST,
      output RSP_VALID, RSP_Z, RSP_FLAGS, STICKY_ZERO, OP_COUNT
   );

endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Accepts one ALU request, registers its operands onto the peer
//   combinational ALU, captures the ALU result one cycle later and presents
//   it on the response channel until it is taken. At most one operation is
//   in flight; a new request may be accepted on the same edge the pending
//   response is taken, giving one operation per two cycles.
//
//   Ports:
//     CLK          rising-edge clock
//     RST_N        asynchronous active-low reset
//     bus          alu_op_sequencer_if.slave (request, ALU, response,
//                  sticky-zero and op-count signals)
//     dbg_state_o  current FSM state
//
//   Build option:
//     ALU_SEQ_ACC_EN  when defined, REQ_ACC=1 at accept substitutes ALU_A
//                     with an accumulator that reloads from RSP_Z at every
//                     capture. When undefined REQ_ACC is ignored.
// ---------------------------------------------------------------------------
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   alu_op_sequencer_if.slave bus,
   output seq_state_e        dbg_state_o
);

   seq_state_e       state_q, state_d;
   logic             req_ready;
   logic             accept;
   logic             capture;
   logic             rsp_hs;

   logic [31:0]      alu_a_q, alu_a_d;
   logic [31:0]      alu_b_q, alu_b_d;
   logic [3:0]       alu_inst_q, alu_inst_d;
   logic [31:0]      rsp_z_q, rsp_z_d;
   logic [3:0]       rsp_flags_q, rsp_flags_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0]      cap_z;
   logic [3:0]       cap_flags;
   logic [31:0]      a_src;

   // -----------------------------------------------------------------------
   // FSM: next state, request ready and capture strobe.
   // In RESP, READY follows RSP_READY combinationally so a new request can
   // be taken on the same edge the current response leaves.
   // -----------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      capture   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (bus.REQ_VALID) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            capture = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            req_ready = bus.RSP_READY;
            if (bus.RSP_READY) state_d = bus.REQ_VALID ? ST_EXEC : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign accept = bus.REQ_VALID & req_ready;
   assign rsp_hs = rsp_valid_q & bus.RSP_READY;

   // -----------------------------------------------------------------------
   // Operand A source (accumulator substitution when built in).
   // -----------------------------------------------------------------------
`ifdef ALU_SEQ_ACC_EN
   logic [31:0] acc_q, acc_d;

   assign a_src = bus.REQ_ACC ? acc_q : bus.REQ_A;
   assign acc_d = capture ? cap_z : acc_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) acc_q <= '0;
      else        acc_q <= acc_d;
   end
`else
   logic unused_req_acc;

   assign unused_req_acc = bus.REQ_ACC;
   assign a_src          = bus.REQ_A;
`endif

   // The undefined opcode never trusts the ALU: result 0, ILLEGAL flag only.
   always_comb begin
      if (alu_inst_q == UNDEF) begin
         cap_z     = '0;
         cap_flags = ILLEGAL_FLAGS;
      end else begin
         cap_z     = bus.ALU_Z;
         cap_flags = bus.ALU_FLAGS;
      end
   end

   // -----------------------------------------------------------------------
   // Datapath next-state.
   // -----------------------------------------------------------------------
   always_comb begin
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_inst_d  = alu_inst_q;
      rsp_z_d     = rsp_z_q;
      rsp_flags_d = rsp_flags_q;
      rsp_valid_d = rsp_valid_q;

      if (accept) begin
         alu_a_d    = a_src;
         alu_b_d    = bus.REQ_B;
         alu_inst_d = bus.REQ_INST;
      end

      if (capture) begin
         rsp_z_d     = cap_z;
         rsp_flags_d = cap_flags;
         rsp_valid_d = 1'b1;
      end else if (rsp_hs) begin
         rsp_valid_d = 1'b0;
      end

      // A zero capture in the same cycle as a clear leaves the flag set.
      sticky_d = (sticky_q & ~bus.STICKY_CLR) | (capture & cap_flags[ZERO]);
      cnt_d    = cnt_q + CNT_W'(rsp_hs);
   end

   // -----------------------------------------------------------------------
   // State registers.
   // -----------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_inst_q  <= '0;
         rsp_z_q     <= '0;
         rsp_flags_q <= '0;
         rsp_valid_q <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_inst_q  <= alu_inst_d;
         rsp_z_q     <= rsp_z_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_valid_q <= rsp_valid_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.REQ_READY   = req_ready;
   assign bus.ALU_A       = alu_a_q;
   assign bus.ALU_B       = alu_b_q;
   assign bus.ALU_INST    = alu_inst_q;
   assign bus.RSP_VALID   = rsp_valid_q;
   assign bus.RSP_Z       = rsp_z_q;
   assign bus.RSP_FLAGS   = rsp_flags_q;
   assign bus.STICKY_ZERO = sticky_q;
   assign bus.OP_COUNT    = cnt_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Bench for alu_op_sequencer. Provides a behavioural peer ALU, drives the
//   request channel, and keeps an expected-response queue that a negedge
//   monitor pops on every response handshake. A narrow OP_COUNT keeps the
//   counter wrap reachable in a short run. Honours ALU_SEQ_ACC_EN.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int TB_CNT_W = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   seq_state_e dbg_state;

   alu_op_sequencer_if #(.CNT_W(TB_CNT_W)) bus ();

   alu_op_sequencer #(.CNT_W(TB_CNT_W)) dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- peer ALU model ----------------
   function automatic logic [35:0] alu_ref(input logic [3:0] inst,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] z;
      logic        c, v;
      w = '0; z = '0; c = 1'b0; v = 1'b0;
      case (inst)
         INCA:   begin w = {1'b0, a} + 33'd1; z = w[31:0]; c = w[32]; v = (a == 32'h7FFF_FFFF); end
         ADD:    begin w = {1'b0, a} + {1'b0, b}; z = w[31:0]; c = w[32];
                       v = (a[31] == b[31]) && (z[31] != a[31]); end
         SUB:    begin w = {1'b0, a} - {1'b0, b}; z = w[31:0]; c = w[32];
                       v = (a[31] != b[31]) && (z[31] != a[31]); end
         AND_OP: z = a & b;
         OR_OP:  z = a | b;
         XOR_OP: z = a ^ b;
         PASSB:  z = b;
         NOTA:   z = ~a;
         ONES:   z = 32'hFFFF_FFFF;
         default: return {4'b0111, 32'hDEAD_BEEF};  // junk the DUT must ignore
      endcase
      return {1'b0, (z == 32'h0), c, v, z};
   endfunction

   assign {bus.ALU_FLAGS, bus.ALU_Z} = alu_ref(bus.ALU_INST, bus.ALU_A, bus.ALU_B);

   // ---------------- scoreboard ----------------
   logic [35:0] exp_q[$];
   logic [35:0] mon_exp;
   logic [31:0] acc_model = '0;
   int          n_cmp = 0;
   int          n_err = 0;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.RSP_VALID === 1'b1 && bus.RSP_READY === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: got z=%h flags=%b, required no response",
                     bus.RSP_Z, bus.RSP_FLAGS);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({bus.RSP_FLAGS, bus.RSP_Z} !== mon_exp) begin
               n_err++;
               $display("FAIL rsp_data: got flags=%b z=%h, required flags=%b z=%h",
                        bus.RSP_FLAGS, bus.RSP_Z, mon_exp[35:32], mon_exp[31:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request and waits for its accept edge. Returns one time unit
   // after that edge (sequencer then in EXEC); waits = cycles spent stalled.
   task automatic send_op(input logic [3:0] inst, input logic [31:0] a,
                          input logic [31:0] b, input logic acc, output int waits);
      logic [31:0] a_eff;
      logic [35:0] e;
      bus.REQ_INST  = inst;
      bus.REQ_A     = a;
      bus.REQ_B     = b;
      bus.REQ_ACC   = acc;
      bus.REQ_VALID = 1'b1;
      waits = 0;
      @(negedge clk);
      while (bus.REQ_READY !== 1'b1 && waits < 50) begin
         @(posedge clk);
         #1;
         waits++;
         @(negedge clk);
      end
      if (bus.REQ_READY !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL req_accept_timeout: got REQ_READY=%b for %0d cycles, required 1",
                  bus.REQ_READY, waits);
         bus.REQ_VALID = 1'b0;
         tick();
         return;
      end
      a_eff = a;
`ifdef ALU_SEQ_ACC_EN
      if (acc) a_eff = acc_model;
`endif
      e = (inst == UNDEF) ? {4'b1000, 32'h0} : alu_ref(inst, a_eff, b);
      acc_model = e[31:0];
      exp_q.push_back(e);
      tick();
      bus.REQ_VALID = 1'b0;
   endtask

   // From EXEC: through the capture edge and the handshake edge.
   task automatic finish_op();
      tick();
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.REQ_VALID  = 1'b0;
      bus.REQ_INST   = '0;
      bus.REQ_A      = '0;
      bus.REQ_B      = '0;
      bus.REQ_ACC    = 1'b0;
      bus.RSP_READY  = 1'b0;
      bus.STICKY_CLR = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.REQ_READY !== 1'b1 || dbg_state !== ST_IDLE) begin
         n_err++;
         $display("FAIL reset_ready: got ready=%b state=%0d, required 1/IDLE", bus.REQ_READY, dbg_state);
      end
      n_cmp++;
      if ({bus.RSP_VALID, bus.RSP_Z, bus.RSP_FLAGS} !== '0) begin
         n_err++;
         $display("FAIL reset_rsp: got v=%b z=%h f=%b, required 0", bus.RSP_VALID, bus.RSP_Z, bus.RSP_FLAGS);
      end
      n_cmp++;
      if ({bus.ALU_A, bus.ALU_B, bus.ALU_INST} !== '0) begin
         n_err++;
         $display("FAIL reset_alu: got a=%h b=%h i=%h, required 0", bus.ALU_A, bus.ALU_B, bus.ALU_INST);
      end
      n_cmp++;
      if ({bus.STICKY_ZERO, bus.OP_COUNT} !== '0) begin
         n_err++;
         $display("FAIL reset_status: got sticky=%b cnt=%0d, required 0", bus.STICKY_ZERO, bus.OP_COUNT);
      end
      tick();
   endtask

   task automatic test_add();
      int w;
      bus.RSP_READY = 1'b1;
      send_op(ADD, 32'd5, 32'd7, 1'b0, w);
      @(negedge clk);
      n_cmp++;
      if (bus.RSP_VALID !== 1'b0) begin
         n_err++;
         $display("FAIL add_latency_early: got RSP_VALID=%b in EXEC, required 0", bus.RSP_VALID);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (bus.RSP_VALID !== 1'b1) begin
         n_err++;
         $display("FAIL add_latency: got RSP_VALID=%b 2 cycles after accept, required 1", bus.RSP_VALID);
      end
      n_cmp++;
      if (bus.RSP_Z !== 32'd12 || bus.RSP_FLAGS !== 4'b0000) begin
         n_err++;
         $display("FAIL add_result: got z=%0d f=%b, required 12/0000", bus.RSP_Z, bus.RSP_FLAGS);
      end
      tick();
      n_cmp++;
      if (bus.OP_COUNT !== TB_CNT_W'(1)) begin
         n_err++;
         $display("FAIL add_count: got %0d, required 1", bus.OP_COUNT);
      end
   endtask

   task automatic test_sticky();
      int w;
      bus.RSP_READY = 1'b1;
      send_op(SUB, 32'd9, 32'd9, 1'b0, w);
      tick();
      @(negedge clk);
      n_cmp++;
      if (bus.RSP_Z !== 32'd0 || bus.RSP_FLAGS !== 4'b0100 || bus.STICKY_ZERO !== 1'b1) begin
         n_err++;
         $display("FAIL sticky_set: got z=%h f=%b sticky=%b, required 0/0100/1",
                  bus.RSP_Z, bus.RSP_FLAGS, bus.STICKY_ZERO);
      end
      tick();
      // clear in the same cycle as another zero capture: set wins
      send_op(SUB, 32'd3, 32'd3, 1'b0, w);
      bus.STICKY_CLR = 1'b1;
      tick();
      bus.STICKY_CLR = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.STICKY_ZERO !== 1'b1) begin
         n_err++;
         $display("FAIL sticky_set_wins: got %b, required 1", bus.STICKY_ZERO);
      end
      tick();
      // plain clear
      bus.STICKY_CLR = 1'b1;
      tick();
      bus.STICKY_CLR = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.STICKY_ZERO !== 1'b0) begin
         n_err++;
         $display("FAIL sticky_clear: got %b, required 0", bus.STICKY_ZERO);
      end
      tick();
   endtask

   task automatic test_illegal();
      int w;
      bus.RSP_READY = 1'b1;
      send_op(UNDEF, 32'h1234_5678, 32'h0000_0009, 1'b0, w);
      tick();
      @(negedge clk);
      n_cmp++;
      if (bus.RSP_Z !== 32'd0 || bus.RSP_FLAGS !== 4'b1000) begin
         n_err++;
         $display("FAIL illegal_result: got z=%h f=%b, required 0/1000", bus.RSP_Z, bus.RSP_FLAGS);
      end
      n_cmp++;
      if ($isunknown({bus.REQ_READY, bus.RSP_VALID, bus.RSP_Z, bus.RSP_FLAGS,
                      bus.STICKY_ZERO, bus.OP_COUNT, bus.ALU_A, bus.ALU_B, bus.ALU_INST})) begin
         n_err++;
         $display("FAIL illegal_no_x: got X/Z on outputs, required none");
      end
      n_cmp++;
      if (bus.STICKY_ZERO !== 1'b0) begin
         n_err++;
         $display("FAIL illegal_sticky: got %b, required 0", bus.STICKY_ZERO);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int w;
      bus.RSP_READY = 1'b0;
      send_op(XOR_OP, 32'hF0F0_1234, 32'h0FF0_4321, 1'b0, w);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.REQ_READY !== 1'b0 || bus.RSP_VALID !== 1'b1 || bus.RSP_Z !== 32'hFF00_5115) begin
            n_err++;
            $display("FAIL backpressure_hold[%0d]: got ready=%b v=%b z=%h, required 0/1/ff005115",
                     i, bus.REQ_READY, bus.RSP_VALID, bus.RSP_Z);
         end
         tick();
      end
      bus.RSP_READY = 1'b1;
      send_op(OR_OP, 32'h00FF_0000, 32'h0000_00FF, 1'b0, w);
      n_cmp++;
      if (w != 0) begin
         n_err++;
         $display("FAIL backpressure_same_edge: got %0d stall cycles, required 0", w);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.RSP_VALID !== 1'b0) begin
         n_err++;
         $display("FAIL backpressure_exec: got RSP_VALID=%b, required 0", bus.RSP_VALID);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (bus.RSP_VALID !== 1'b1 || bus.RSP_Z !== 32'h00FF_00FF) begin
         n_err++;
         $display("FAIL backpressure_next: got v=%b z=%h, required 1/00ff00ff", bus.RSP_VALID, bus.RSP_Z);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int w;
      bus.RSP_READY = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send_op(4'($urandom_range(0, 9)), $urandom, $urandom, 1'b0, w);
         if (i > 0) begin
            n_cmp++;
            if (w != 1) begin
               n_err++;
               $display("FAIL b2b_rate[%0d]: got %0d stall cycles, required 1", i, w);
            end
         end
      end
      finish_op();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_midflight();
      int w;
      bus.RSP_READY = 1'b1;
      send_op(SUB, 32'd4, 32'd4, 1'b0, w);
      finish_op();
      send_op(ADD, 32'h0000_1234, 32'h0000_0010, 1'b0, w);
      finish_op();
      send_op(XOR_OP, 32'h0000_AAAA, 32'h0000_5555, 1'b0, w);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.RSP_VALID, bus.RSP_Z, bus.RSP_FLAGS, bus.ALU_A, bus.ALU_B, bus.ALU_INST,
           bus.STICKY_ZERO, bus.OP_COUNT} !== '0) begin
         n_err++;
         $display("FAIL reset_async: got v=%b z=%h f=%b a=%h b=%h i=%h s=%b c=%0d, required all 0",
                  bus.RSP_VALID, bus.RSP_Z, bus.RSP_FLAGS, bus.ALU_A, bus.ALU_B, bus.ALU_INST,
                  bus.STICKY_ZERO, bus.OP_COUNT);
      end
      exp_q.delete();
      acc_model = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.RSP_VALID !== 1'b0 || bus.REQ_READY !== 1'b1) begin
            n_err++;
            $display("FAIL reset_dropped[%0d]: got v=%b ready=%b, required 0/1", i, bus.RSP_VALID, bus.REQ_READY);
         end
      end
      tick();
   endtask

   task automatic test_count_wrap();
      int w;
      bus.RSP_READY = 1'b1;
      for (int i = 0; i < 255; i++)
         send_op(4'($urandom_range(0, 9)), $urandom, $urandom, 1'b0, w);
      finish_op();
      n_cmp++;
      if (bus.OP_COUNT !== '1) begin
         n_err++;
         $display("FAIL count_full: got %0d, required %0d", bus.OP_COUNT, (1 << TB_CNT_W) - 1);
      end
      send_op(ADD, 32'd1, 32'd2, 1'b0, w);
      finish_op();
      n_cmp++;
      if (bus.OP_COUNT !== '0) begin
         n_err++;
         $display("FAIL count_wrap: got %0d, required 0", bus.OP_COUNT);
      end
   endtask

`ifdef ALU_SEQ_ACC_EN
   task automatic test_acc();
      int w;
      bus.RSP_READY = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         if (k == 1) send_op(INCA, 32'd0, 32'd0, 1'b0, w);
         else        send_op(INCA, 32'hFFFF_0000, 32'd0, 1'b1, w);
         tick();
         @(negedge clk);
         n_cmp++;
         if (bus.RSP_Z !== 32'(k)) begin
            n_err++;
            $display("FAIL acc_seq[%0d]: got %0d, required %0d", k, bus.RSP_Z, k);
         end
         tick();
      end
   endtask
`else
   task automatic test_acc_ignored();
      int w;
      bus.RSP_READY = 1'b1;
      send_op(ADD, 32'd10, 32'd1, 1'b1, w);
      @(negedge clk);
      n_cmp++;
      if (bus.ALU_A !== 32'd10) begin
         n_err++;
         $display("FAIL acc_ignored_a: got %h, required 0000000a", bus.ALU_A);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (bus.RSP_Z !== 32'd11) begin
         n_err++;
         $display("FAIL acc_ignored_z: got %0d, required 11", bus.RSP_Z);
      end
      tick();
   endtask
`endif

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_add();
      test_sticky();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      test_count_wrap();
`ifdef ALU_SEQ_ACC_EN
      test_acc();
`else
      test_acc_ignored();
`endif
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL final_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
- REQ-001 SHALL have parameter CNT_W, default 16: width of OP_COUNT.
- REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
- REQ-003 SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
- REQ-004 SHALL have port REQ_VALID, input, 1: request present.
- REQ-005 SHALL have port REQ_READY, output, 1: request accepted this cycle when REQ_VALID is also high.
- REQ-006 SHALL have port REQ_INST, input, 4: ALU opcode.
- REQ-007 SHALL have ports REQ_A and REQ_B, input, 32 each: operands.
- REQ-008 SHALL have port REQ_ACC, input, 1: accumulate request (see Configuration).
- REQ-009 SHALL have ports ALU_A and ALU_B (output, 32 each) and ALU_INST (output, 4): registered drive to the combinational ALU.
- REQ-010 SHALL have ports ALU_Z (input, 32) and ALU_FLAGS (input, 4): ALU result and flags {rsvd, Zero, Carry, Ovf}.
- REQ-011 SHALL have ports RSP_VALID (output, 1) and RSP_READY (input, 1): response handshake.
- REQ-012 SHALL have ports RSP_Z (output, 32) and RSP_FLAGS (output, 4): captured result and flags.
- REQ-013 SHALL have ports STICKY_ZERO (output, 1) and STICKY_CLR (input, 1).
- REQ-014 SHALL have port OP_COUNT, output, CNT_W: completed-response count.

Function
- REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
- REQ-016 SHALL drive REQ_READY = (state==IDLE) | (state==RESP & RSP_READY); the combinational RSP_READY->REQ_READY path is intended.
- REQ-017 On accept: SHALL register REQ_INST/REQ_A/REQ_B into ALU_INST/ALU_A/ALU_B and enter EXEC.
- REQ-018 From EXEC: SHALL capture ALU_Z/ALU_FLAGS into RSP_Z/RSP_FLAGS, set RSP_VALID, and enter RESP unconditionally. Accept-edge to RSP_VALID latency is 2 cycles.
- REQ-019 In RESP: RSP_READY & !REQ_VALID -> IDLE, with RSP_VALID cleared; RSP_READY & REQ_VALID -> EXEC (back-to-back; new op accepted on the same edge); !RSP_READY -> stay, with RSP_Z/RSP_FLAGS held stable.
- REQ-020 Throughput SHALL be one op per 2 cycles maximum.
- REQ-021 ALU_* outputs SHALL hold their last value outside EXEC.
- REQ-022 Opcode 4'h6 (undefined) SHALL be accepted; the capture SHALL force RSP_Z=0 and RSP_FLAGS=4'b1000, ignoring ALU_Z/ALU_FLAGS.
- REQ-023 STICKY_ZERO SHALL set on any capture with RSP_FLAGS[2]=1 and clear on STICKY_CLR; set wins when both occur in the same cycle.
- REQ-024 OP_COUNT SHALL increment on each RSP_VALID & RSP_READY and wrap from all-ones to 0.

Reset
- REQ-025 RST_N low SHALL immediately force IDLE, REQ_READY=1 after release, and RSP_VALID=0; RSP_Z, RSP_FLAGS, ALU_A, ALU_B, ALU_INST, STICKY_ZERO, OP_COUNT and the accumulator SHALL all be 0.
- REQ-026 Reset during EXEC or RESP SHALL drop the in-flight op; no response is produced after release.

Configuration
- REQ-027 Macro ALU_SEQ_ACC_EN defined: REQ_ACC=1 at accept SHALL substitute ALU_A with the accumulator, which is loaded with RSP_Z at every capture (reset 0).
- REQ-028 Macro ALU_SEQ_ACC_EN undefined: REQ_ACC SHALL be ignored, the accumulator SHALL be absent, and ALU_A SHALL always come from REQ_A.

Structure
- REQ-029 Shared package alu_pkg SHALL hold the opcode constants (INCA..ONES), the flag bit indices (ZERO=2, CARRY=1, OVF=0, ILLEGAL=3) and the FSM state encoding.
- REQ-030 SHALL have no sub-module; the ALU remains a peer instance wired at functional-unit level.

Verification
- REQ-031 ADD, A=5, B=7, RSP_READY=1 -> RSP_VALID 2 cycles after accept; RSP_Z=12; RSP_FLAGS=0; OP_COUNT=1.
- REQ-032 SUB, A=9, B=9 -> RSP_Z=0, RSP_FLAGS[2]=1, STICKY_ZERO=1; then STICKY_CLR and a same-cycle zero capture -> STICKY_ZERO stays 1.
- REQ-033 Opcode 4'h6 -> RSP_Z=0, RSP_FLAGS=4'b1000, with no X on outputs.
- REQ-034 RSP_READY held low 5 cycles -> REQ_READY=0 and RSP_Z stable; then release with REQ_VALID high -> same-edge accept, next RSP 2 cycles later.
- REQ-035 RST_N asserted in EXEC -> all outputs 0 asynchronously and no response after release; OP_COUNT preset path 16'hFFFF + 1 handshake -> 0.
- REQ-036 With ALU_SEQ_ACC_EN: INCA A=0 then INCA REQ_ACC=1 three times -> RSP_Z sequence 1, 2, 3, 4.
